regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 85 ++++++++
 tb/tb_regfile_scoreboard.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, NUM_READ combinational read ports and a registered debug port.
// Optional same-cycle write-back forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rs_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rs_data,
  output logic [NUM_READ-1:0]            rs_busy,
  input  logic                           issue_valid,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  input  logic                           wb_valid,
  input  logic [ADDR_WIDTH-1:0]          wb_rd,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  output logic                           stall,
  output logic [ADDR_WIDTH:0]            pending_count,
  input  logic [ADDR_WIDTH-1:0]          dbg_addr,
  output logic [DATA_WIDTH-1:0]          dbg_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [CW-1:0]         count;
  logic                  wb_en;
  logic                  issue_en;
  logic                  set_new;
  logic                  clr_old;
  logic [DATA_WIDTH-1:0] dbg_next;

  // Register 0 is never written and never marked busy, so it reads 0 for free.
  assign wb_en    = wb_valid && (wb_rd != '0);
  assign issue_en = issue_valid && (issue_rd != '0);

  // Count tracks busy transitions, not requests: re-issue or write-back to an idle reg is net 0.
  assign set_new  = issue_en && !busy[issue_rd];
  assign clr_old  = wb_en && busy[wb_rd] && !(issue_en && (issue_rd == wb_rd));

  assign dbg_next = (wb_en && (wb_rd == dbg_addr)) ? wb_data : regs[dbg_addr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[ADDR_WIDTH'(i)] <= '0;
      end
      busy     <= '0;
      count    <= '0;
      dbg_data <= '0;
    end else begin
      if (wb_en) begin
        regs[wb_rd] <= wb_data;
        busy[wb_rd] <= 1'b0;
      end
      // Later assignment wins, so an issue to the write-back target keeps it busy.
      if (issue_en) begin
        busy[issue_rd] <= 1'b1;
      end
      count    <= count + CW'(set_new) - CW'(clr_old);
      dbg_data <= dbg_next;
    end
  end

  assign pending_count = count;
  assign stall         = |rs_busy;

  for (genvar g = 0; g < NUM_READ; g++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    assign addr = rs_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wb_en && (wb_rd == addr);
    assign rs_data[g*DATA_WIDTH +: DATA_WIDTH] = hit ? wb_data : regs[addr];
    assign rs_busy[g] = hit ? (issue_en && (issue_rd == addr)) : busy[addr];
`else
    assign rs_data[g*DATA_WIDTH +: DATA_WIDTH] = regs[addr];
    assign rs_busy[g] = busy[addr];
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: driver pushes expected outputs from an array model,
// an independent monitor pops and compares them mid-cycle.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NR*AW-1:0]  rs_addr;
  logic [NR*DW-1:0]  rs_data;
  logic [NR-1:0]     rs_busy;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              wb_valid;
  logic [AW-1:0]     wb_rd;
  logic [DW-1:0]     wb_data;
  logic              stall;
  logic [AW:0]       pending_count;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_data;

  always #5 clock = ~clock;

  regfile_scoreboard #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_READ  (NR)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rs_addr      (rs_addr),
    .rs_data      (rs_data),
    .rs_busy      (rs_busy),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall        (stall),
    .pending_count(pending_count),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  typedef struct {
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic [NR-1:0] busy;
    logic          stall;
    logic [AW:0]   cnt;
    logic [DW-1:0] dbg;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_data [32];
  bit            m_busy [32];
  logic [DW-1:0] m_dbg;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are settled 3 time units after the falling edge, well before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rs_data0", 64'(rs_data[DW-1:0]), 64'(e.data0));
        chk("rs_data1", 64'(rs_data[2*DW-1:DW]), 64'(e.data1));
        chk("rs_busy", 64'(rs_busy), 64'(e.busy));
        chk("stall", 64'(stall), 64'(e.stall));
        chk("pending_count", 64'(pending_count), 64'(e.cnt));
        chk("dbg_data", 64'(dbg_data), 64'(e.dbg));
      end
    end
  end

  function automatic void read_port(input logic [AW-1:0] a, input bit iv, input logic [AW-1:0] ird,
                                    input bit wv, input logic [AW-1:0] wrd, input logic [DW-1:0] wd,
                                    output logic [DW-1:0] d, output logic b);
    d = (a == 0) ? '0 : m_data[a];
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (wv && wrd == a && a != 0) begin
      d = wd;
      b = iv && (ird == a);
    end
`endif
  endfunction

  // One clock cycle: drive after the falling edge, publish expectations, then advance the model
  // to what the coming rising edge should produce.
  task automatic step(input bit rn, input bit iv, input logic [AW-1:0] ird,
                      input bit wv, input logic [AW-1:0] wrd, input logic [DW-1:0] wd,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] dba);
    exp_t e;
    int   pop;
    @(negedge clock);
    #1;
    reset_n     = rn;
    issue_valid = iv;
    issue_rd    = ird;
    wb_valid    = wv;
    wb_rd       = wrd;
    wb_data     = wd;
    rs_addr     = {a1, a0};
    dbg_addr    = dba;
    if (!rn) begin
      for (int i = 0; i < 32; i++) begin
        m_data[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_dbg = '0;
    end
    read_port(a0, iv, ird, wv, wrd, wd, e.data0, e.busy[0]);
    read_port(a1, iv, ird, wv, wrd, wd, e.data1, e.busy[1]);
    e.stall = |e.busy;
    pop = 0;
    for (int i = 0; i < 32; i++) pop += int'(m_busy[i]);
    e.cnt = (AW+1)'(pop);
    e.dbg = m_dbg;
    exp_q.push_back(e);
    if (rn) begin
      if (wv && wrd != 0) begin
        m_data[wrd] = wd;
        m_busy[wrd] = 1'b0;
      end
      if (iv && ird != 0) m_busy[ird] = 1'b1;
      m_dbg = (dba == 0) ? '0 : m_data[dba];
    end
  endtask

  initial begin
    reset_n     = 1'b1;
    issue_valid = 1'b0;
    issue_rd    = '0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    rs_addr     = '0;
    dbg_addr    = '0;
    m_dbg       = '0;
    for (int i = 0; i < 32; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
    end
    #2 reset_n = 1'b0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 2, 0);

    // Reset with data present, then reset held across an edge with issue/write-back pending.
    step(1, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0, 5);
    step(1, 0, 0, 0, 0, 0, 5, 5, 5);
    step(0, 0, 0, 0, 0, 0, 5, 5, 5);
    step(0, 1, 4, 1, 6, 32'h0BAD0BAD, 4, 6, 6);
    step(1, 0, 0, 0, 0, 0, 4, 6, 6);

    // Issue x3, observe busy, write back, observe clear.
    step(1, 1, 3, 0, 0, 0, 3, 0, 0);
    step(1, 0, 0, 0, 0, 0, 3, 0, 0);
    step(1, 0, 0, 1, 3, 32'h1234, 3, 0, 3);
    step(1, 0, 0, 0, 0, 0, 3, 0, 3);

    // Issue and write-back colliding on x7 while already busy.
    step(1, 1, 7, 0, 0, 0, 7, 0, 0);
    step(1, 1, 7, 1, 7, 32'h55, 7, 0, 7);
    step(1, 0, 0, 0, 0, 0, 7, 7, 7);
    step(1, 0, 0, 1, 7, 32'h66, 7, 0, 7);
    // Collision on an idle register: count must rise by one.
    step(1, 1, 8, 1, 8, 32'h77, 8, 0, 8);
    step(1, 0, 0, 1, 8, 32'h78, 8, 0, 8);

    // Register 0 ignores everything.
    step(1, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Write-back visibility on read port 1, with and without a same-cycle issue.
    step(1, 0, 0, 1, 9, 32'hA5A5A5A5, 0, 9, 9);
    step(1, 0, 0, 0, 0, 0, 0, 9, 9);
    step(1, 1, 9, 1, 9, 32'h5A5A5A5A, 9, 9, 0);
    step(1, 0, 0, 1, 9, 32'h1, 9, 9, 0);

    // Fill the scoreboard, then debug readback after a write-back.
    for (int i = 1; i < 32; i++) step(1, 1, AW'(i), 0, 0, 0, AW'(i), 0, 0);
    step(1, 1, 31, 0, 0, 0, 31, 1, 0);
    step(1, 0, 0, 1, 1, 32'd7, 1, 2, 1);
    step(1, 0, 0, 0, 0, 0, 1, 2, 1);
    for (int i = 1; i < 32; i++) step(1, 0, 0, 1, AW'(i), $urandom, AW'(i), AW'(32 - i), AW'(i));

    // Randomized traffic biased toward a few registers to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] ird, wrd, a0, a1, dba;
      bit            rn;
      rn  = ($urandom_range(0, 59) != 0);
      ird = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wrd = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      a0  = ($urandom_range(0, 2) == 0) ? wrd : AW'($urandom_range(0, 7));
      a1  = ($urandom_range(0, 2) == 0) ? ird : AW'($urandom);
      dba = ($urandom_range(0, 1) != 0) ? wrd : AW'($urandom_range(0, 7));
      step(rn, bit'($urandom_range(0, 1)), ird, bit'($urandom_range(0, 1)), wrd, $urandom, a0, a1, dba);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    #5;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
